// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet decoder family.
// Holds the frame-parser state encoding, the default SYNC value and id-width helper.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h44;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  // Width of an index able to address n items, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_packet_decoder_if.sv
// Decoder bus: received-byte strobe towards the decoder, committed packets and status back.
interface uart_packet_decoder_if #(
  parameter int PAYLOAD_BYTES = 10,
  parameter int N_CH          = 2
) ();
  import uart_pkt_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic [7:0]                      rx_data;
  logic                            rx_valid;
  logic [N_CH*PAYLOAD_BYTES*8-1:0] payload;
  logic                            frame_valid;
  logic [CH_W-1:0]                 frame_ch;
  logic [7:0]                      err_count;
  logic                            busy;

  modport master (
    output rx_data, rx_valid,
    input  payload, frame_valid, frame_ch, err_count, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output payload, frame_valid, frame_ch, err_count, busy
  );

endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: reloads on every byte, counts down while enabled, flags expiry.
// CYCLES = 0 disables it; expiry is reported on the CYCLES-th idle cycle after a restart.
module uart_byte_timeout #(
  parameter int CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expired
);
  localparam int                CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LOAD  = (CYCLES > 0) ? CNT_W'(CYCLES - 1) : '0;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= LOAD;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (CYCLES != 0) && i_enable && (r_cnt == '0);

endmodule

// File: rtl/uart_packet_decoder.sv
// Frames UART bytes (SYNC, TYPE, PAYLOAD_BYTES data) into per-channel payload registers.
// Define UART_PKT_CHECKSUM_EN to require a trailing XOR byte over TYPE and payload.
module uart_packet_decoder
  import uart_pkt_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 10,
  parameter int         N_CH           = 2,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 65000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_packet_decoder_if.slave bus
);
  localparam int              PW       = PAYLOAD_BYTES * 8;
  localparam int              CW       = ch_width(N_CH);
  localparam int              IW       = ch_width(PAYLOAD_BYTES);
  localparam logic [IW-1:0]   LAST_IDX = IW'(PAYLOAD_BYTES - 1);
  localparam logic [7:0]      N_CH_B   = 8'(N_CH);

  state_e          r_state;
  state_e          w_state_next;
  logic [CW-1:0]   r_ch;
  logic [CW-1:0]   r_frame_ch;
  logic [IW-1:0]   r_idx;
  logic [PW-1:0]   r_shadow;
  logic [PW-1:0]   w_shadow_next;
  logic            r_frame_valid;
  logic [7:0]      r_err_count;
  logic            w_byte;
  logic            w_in_frame;
  logic            w_expired;
  logic            w_commit;
  logic            w_err;
  logic            w_ch_ok;

  assign w_byte     = bus.rx_valid;
  assign w_in_frame = (r_state != ST_IDLE);
  assign w_ch_ok    = (bus.rx_data < N_CH_B);

  uart_byte_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_byte),
    .i_enable  (w_in_frame),
    .o_expired (w_expired)
  );

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       w_sum_ok;

  assign w_sum_ok = (bus.rx_data == r_xor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor <= '0;
    end else if (w_byte && (r_state == ST_TYPE)) begin
      r_xor <= bus.rx_data;
    end else if (w_byte && (r_state == ST_PAYLOAD)) begin
      r_xor <= r_xor ^ bus.rx_data;
    end
  end
`endif

  always_comb begin
    w_state_next  = r_state;
    w_commit      = 1'b0;
    w_err         = 1'b0;
    w_shadow_next = r_shadow;
    case (r_state)
      ST_IDLE: begin
        if (w_byte && (bus.rx_data == SYNC_BYTE)) w_state_next = ST_TYPE;
      end
      ST_TYPE: begin
        if (w_byte) begin
          if (w_ch_ok) begin
            w_state_next = ST_PAYLOAD;
          end else begin
            w_err        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_byte) begin
          // Merge the incoming byte so a commit on the last byte sees the full frame.
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (r_idx == IW'(k)) w_shadow_next[k*8 +: 8] = bus.rx_data;
          end
          if (r_idx == LAST_IDX) begin
`ifdef UART_PKT_CHECKSUM_EN
            w_state_next = ST_CHECK;
`else
            w_commit     = 1'b1;
            w_state_next = ST_IDLE;
`endif
          end
        end
      end
`ifdef UART_PKT_CHECKSUM_EN
      ST_CHECK: begin
        if (w_byte) begin
          w_state_next = ST_IDLE;
          if (w_sum_ok) w_commit = 1'b1;
          else          w_err    = 1'b1;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
    // A byte landing on the expiry cycle takes priority over the timeout.
    if (!w_byte && w_expired) begin
      w_state_next = ST_IDLE;
      w_err        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ch          <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_ch    <= '0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_shadow      <= w_shadow_next;
      r_frame_valid <= w_commit;
      if (w_commit) r_frame_ch <= r_ch;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_byte && (r_state == ST_TYPE)) begin
        r_ch  <= bus.rx_data[CW-1:0];
        r_idx <= '0;
      end else if (w_byte && (r_state == ST_PAYLOAD)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
    logic [PW-1:0] r_slot;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_slot <= '0;
      end else if (w_commit && (r_ch == CW'(gi))) begin
        r_slot <= w_shadow_next;
      end
    end

    assign bus.payload[gi*PW +: PW] = r_slot;
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_ch    = r_frame_ch;
  assign bus.err_count   = r_err_count;
  assign bus.busy        = w_in_frame;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Self-checking bench for uart_packet_decoder: directed table, corner sequences and
// randomized frames compared every cycle against a byte-queue reference model.
module tb_uart_packet_decoder;
  import uart_pkt_pkg::*;

  localparam int         PB   = 10;
  localparam int         NCH  = 2;
  localparam int         TO   = 40;
  localparam int         PAYW = NCH * PB * 8;
  localparam int         CW   = ch_width(NCH);
  localparam logic [7:0] SYNC = 8'h44;
`ifdef UART_PKT_CHECKSUM_EN
  localparam bit         CSUM = 1'b1;
`else
  localparam bit         CSUM = 1'b0;
`endif
  localparam int         FLEN = 1 + PB + (CSUM ? 1 : 0);
  localparam logic [PB*8-1:0] EXP_CH1 = 80'h1312_1110_0F0E_0D0C_0B0A;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_packet_decoder_if #(.PAYLOAD_BYTES(PB), .N_CH(NCH)) bus ();

  uart_packet_decoder #(
    .PAYLOAD_BYTES  (PB),
    .N_CH           (NCH),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes collected since SYNC, gap since last byte, committed slots.
  bit              m_in_frame;
  logic [7:0]      m_q[$];
  int              m_gap;
  logic [PAYW-1:0] m_payload;
  bit              m_fv;
  logic [CW-1:0]   m_ch;
  int              m_err;

  logic [7:0] tx[$];

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         fv;
    bit         busy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [PAYW-1:0] act, input logic [PAYW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_q.delete();
    m_gap      = 0;
    m_payload  = '0;
    m_fv       = 1'b0;
    m_ch       = '0;
    m_err      = 0;
  endtask

  task automatic model_reject();
    m_in_frame = 1'b0;
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    logic [7:0] x;
    m_fv = 1'b0;
    if (!m_in_frame) begin
      if (v && d == SYNC) begin
        m_in_frame = 1'b1;
        m_q.delete();
        m_gap = 0;
      end
    end else if (v) begin
      m_q.push_back(d);
      m_gap = 0;
      if (m_q.size() == 1 && int'(d) >= NCH) begin
        model_reject();
      end else if (m_q.size() == FLEN) begin
        x = '0;
        for (int k = 0; k <= PB; k++) x ^= m_q[k];
        if (CSUM && x != m_q[FLEN-1]) begin
          model_reject();
        end else begin
          for (int k = 0; k < PB; k++) m_payload[int'(m_q[0])*PB*8 + k*8 +: 8] = m_q[k+1];
          m_ch       = CW'(m_q[0]);
          m_fv       = 1'b1;
          m_in_frame = 1'b0;
        end
      end
    end else begin
      m_gap++;
      if (m_gap == TO) model_reject();
    end
  endtask

  task automatic compare_all();
    chk("frame_valid", PAYW'(bus.frame_valid), PAYW'(m_fv));
    chk("frame_ch",    PAYW'(bus.frame_ch),    PAYW'(m_ch));
    chk("err_count",   PAYW'(bus.err_count),   PAYW'(m_err));
    chk("busy",        PAYW'(bus.busy),        PAYW'(m_in_frame));
    chk("payload",     bus.payload,            m_payload);
  endtask

  // One clock cycle: drive at a falling edge, let the rising edge act, sample at the next fall.
  task automatic cyc(input bit v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(negedge clk);
    model_step(v, d);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_tx(input int from, input int upto, input int max_gap);
    for (int i = from; i < upto; i++) begin
      cyc(1'b1, tx[i]);
      if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic mk_frame(input logic [7:0] ch, input bit bad_sum);
    logic [7:0] x;
    logic [7:0] b;
    tx.delete();
    tx.push_back(SYNC);
    tx.push_back(ch);
    x = ch;
    for (int k = 0; k < PB; k++) begin
      b = 8'($urandom);
      tx.push_back(b);
      x ^= b;
    end
    if (CSUM) tx.push_back(bad_sum ? (x ^ 8'h5A) : x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int e0;
    int kind;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle(2);

    // Directed frame on channel 1 with payload 0A..13.
    tbl.push_back('{1'b1, SYNC,  1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1});
    for (int k = 0; k < PB; k++) begin
      if (k == PB - 1 && !CSUM) tbl.push_back('{1'b1, 8'(8'h0A + k), 1'b1, 1'b0});
      else                      tbl.push_back('{1'b1, 8'(8'h0A + k), 1'b0, 1'b1});
    end
    if (CSUM) tbl.push_back('{1'b1, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].d);
      chk("tbl_fv",   PAYW'(bus.frame_valid), PAYW'(tbl[i].fv));
      chk("tbl_busy", PAYW'(bus.busy),        PAYW'(tbl[i].busy));
    end
    chk("tbl_frame_ch", PAYW'(bus.frame_ch), PAYW'(1));
    chk("tbl_ch1",      PAYW'(bus.payload[PB*8 +: PB*8]), PAYW'(EXP_CH1));
    chk("tbl_ch0",      PAYW'(bus.payload[0 +: PB*8]),    PAYW'(0));

    // Bad channel, then a good frame on channel 0.
    cyc(1'b1, SYNC);
    cyc(1'b1, 8'h05);
    chk("badch_err",  PAYW'(bus.err_count), PAYW'(1));
    chk("badch_busy", PAYW'(bus.busy),      PAYW'(0));
    mk_frame(8'h00, 1'b0);
    send_tx(0, FLEN + 1, 0);
    chk("after_badch_fv", PAYW'(bus.frame_valid), PAYW'(1));
    chk("after_badch_ch", PAYW'(bus.frame_ch),    PAYW'(0));

    // Timeout after three payload bytes.
    mk_frame(8'h00, 1'b0);
    send_tx(0, 5, 0);
    idle(TO - 1);
    chk("to_busy_before", PAYW'(bus.busy), PAYW'(1));
    idle(1);
    chk("to_busy_after", PAYW'(bus.busy),      PAYW'(0));
    chk("to_err",        PAYW'(bus.err_count), PAYW'(2));

    // A byte on the expiry cycle wins.
    mk_frame(8'h01, 1'b0);
    send_tx(0, 5, 0);
    idle(TO - 1);
    cyc(1'b1, tx[5]);
    chk("to_edge_busy", PAYW'(bus.busy),      PAYW'(1));
    chk("to_edge_err",  PAYW'(bus.err_count), PAYW'(2));
    send_tx(6, FLEN + 1, 0);
    chk("to_edge_commit", PAYW'(bus.frame_valid), PAYW'(1));

`ifdef UART_PKT_CHECKSUM_EN
    // Known checksum over TYPE 00 and payload 01..0A is 0x0B.
    for (int pass = 0; pass < 2; pass++) begin
      e0 = m_err;
      cyc(1'b1, SYNC);
      cyc(1'b1, 8'h00);
      for (int k = 1; k <= PB; k++) cyc(1'b1, 8'(k));
      cyc(1'b1, (pass == 0) ? 8'h0B : 8'h0C);
      chk("csum_fv",  PAYW'(bus.frame_valid), PAYW'((pass == 0) ? 1 : 0));
      chk("csum_err", PAYW'(bus.err_count),   PAYW'((pass == 0) ? e0 : e0 + 1));
    end
`endif

    // Stray bytes: 12 ignored, 44 syncs, 44 as TYPE errors, 00 and payload ignored.
    e0 = m_err;
    cyc(1'b1, 8'h12);
    cyc(1'b1, SYNC);
    cyc(1'b1, SYNC);
    cyc(1'b1, 8'h00);
    for (int k = 1; k <= PB; k++) cyc(1'b1, 8'(k));
    chk("stray_err",  PAYW'(bus.err_count), PAYW'(e0 + 1));
    chk("stray_busy", PAYW'(bus.busy),      PAYW'(0));

    // Randomized traffic.
    for (int f = 0; f < 200; f++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        mk_frame(8'($urandom_range(0, NCH - 1)), 1'b0);
        send_tx(0, tx.size(), 2);
      end else if (kind == 6) begin
        mk_frame(8'($urandom_range(NCH, 255)), 1'b0);
        send_tx(0, tx.size(), 2);
      end else if (kind == 7) begin
        mk_frame(8'($urandom_range(0, NCH - 1)), 1'b1);
        send_tx(0, tx.size(), 2);
      end else if (kind == 8) begin
        cyc(1'b1, 8'($urandom));
      end else begin
        mk_frame(8'($urandom_range(0, NCH - 1)), 1'b0);
        send_tx(0, int'($urandom_range(1, FLEN)), 1);
        idle(TO + 3);
      end
    end
    idle(TO + 3);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, SYNC);
      cyc(1'b1, 8'h05);
    end
    chk("sat_err", PAYW'(bus.err_count), PAYW'(255));

    // Asynchronous reset in the middle of a frame.
    cyc(1'b1, SYNC);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'hA5);
    cyc(1'b1, 8'h5A);
    bus.rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_payload", bus.payload,             PAYW'(0));
    chk("rst_fv",      PAYW'(bus.frame_valid),  PAYW'(0));
    chk("rst_ch",      PAYW'(bus.frame_ch),     PAYW'(0));
    chk("rst_err",     PAYW'(bus.err_count),    PAYW'(0));
    chk("rst_busy",    PAYW'(bus.busy),         PAYW'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    mk_frame(8'h00, 1'b0);
    send_tx(0, FLEN + 1, 0);
    chk("post_rst_fv", PAYW'(bus.frame_valid), PAYW'(1));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
